// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the Mips16 fetch PC sequencer.
// Holds the PC width, reset vector, FSM state encoding and small PC helpers.
package pc_sequencer_pkg;

  localparam int PC_WIDTH = 10;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t RESET_VECTOR = 10'd0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic valid;
    pc_t  target;
  } redirect_t;

  // Sequential successor; wraps silently at the top of the address space.
  function automatic pc_t pc_inc(input pc_t p);
    return p + pc_t'(1'b1);
  endfunction

  // EX-stage branch is older than the ID-stage jump, so it wins a same-cycle collision.
  function automatic redirect_t select_live(input logic branch_taken, input pc_t branch_target,
                                            input logic jump, input pc_t jump_target);
    redirect_t r;
    r.valid  = branch_taken | jump;
    r.target = branch_taken ? branch_target : jump_target;
    return r;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer, the redirect sources and the IF stage.
// master drives control/targets and observes fetch state; slave is the sequencer.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
  ();

  logic stall;
  logic branch_taken;
  pc_t  branch_target;
  logic jump;
  pc_t  jump_target;
  logic halt;
  pc_t  pc;
  pc_t  pc_plus1;
  logic fetch_valid;
  logic flush;
  logic redirect_pending;
  logic halted;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, halt,
    input  pc, pc_plus1, fetch_valid, flush, redirect_pending, halted
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, halt,
    output pc, pc_plus1, fetch_valid, flush, redirect_pending, halted
  );

endinterface

// File: rtl/pc_sequencer_redirect_buffer.sv
// Single-entry redirect holding register used while the pipeline is stalled.
// The first capture wins; later captures are dropped until the entry is cleared.
module pc_sequencer_redirect_buffer
  import pc_sequencer_pkg::*;
  (
    input  logic clk,
    input  logic rst_n,
    input  logic capture,
    input  logic clear,
    input  pc_t  target_in,
    output logic valid,
    output pc_t  target
  );

  // Holding register: clear dominates, otherwise load only when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      target <= {PC_WIDTH{1'b0}};
    end else if (clear) begin
      valid  <= 1'b0;
      target <= target;
    end else if (capture && !valid) begin
      valid  <= 1'b1;
      target <= target_in;
    end else begin
      valid  <= valid;
      target <= target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the Mips16 core: sequential fetch, branch/jump redirects,
// redirect buffering across stalls, one-cycle flush per applied redirect, and HALT.
module pc_sequencer
  import pc_sequencer_pkg::*;
  #(
    parameter pc_t RESET_PC = RESET_VECTOR
  )
  (
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.slave   bus
  );

  seq_state_t state_r;
  seq_state_t state_s;
  pc_t        pc_r;
  pc_t        pc_s;
  logic       flush_r;
  logic       flush_s;
  logic       fetch_valid_r;
  logic       halted_r;
  logic       capture_s;
  logic       clear_s;
  logic       pend_valid_s;
  pc_t        pend_target_s;
  redirect_t  live_s;
  redirect_t  redirect_s;

  pc_sequencer_redirect_buffer u_redirect_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture_s),
    .clear     (clear_s),
    .target_in (live_s.target),
    .valid     (pend_valid_s),
    .target    (pend_target_s)
  );

  // Effective redirect: a buffered (older) redirect beats a live one.
  always_comb begin
    live_s = select_live(bus.branch_taken, bus.branch_target, bus.jump, bus.jump_target);
    redirect_s.valid = pend_valid_s | live_s.valid;
    if (pend_valid_s) begin
      redirect_s.target = pend_target_s;
    end else begin
      redirect_s.target = live_s.target;
    end
  end

  // Next-state and next-PC logic; RUN and STALL share rules except for fetch_valid.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    flush_s   = 1'b0;
    capture_s = 1'b0;
    clear_s   = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_s = ST_RUN;
      end
      ST_RUN, ST_STALL: begin
        if (redirect_s.valid) begin
          // A redirect squashes a younger halt in the same cycle.
          if (bus.stall) begin
            capture_s = live_s.valid;
            state_s   = ST_STALL;
          end else begin
            pc_s    = redirect_s.target;
            flush_s = 1'b1;
            clear_s = 1'b1;
            state_s = ST_RUN;
          end
        end else if (bus.halt) begin
          state_s = ST_HALT;
        end else if (bus.stall) begin
          state_s = ST_STALL;
        end else begin
          pc_s    = pc_inc(pc_r);
          state_s = ST_RUN;
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_BOOT;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      flush_r       <= 1'b0;
      fetch_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      flush_r       <= flush_s;
      fetch_valid_r <= (state_s == ST_RUN);
      halted_r      <= (state_s == ST_HALT);
    end
  end

  assign bus.pc               = pc_r;
  assign bus.pc_plus1         = pc_inc(pc_r);
  assign bus.fetch_valid      = fetch_valid_r;
  assign bus.flush            = flush_r;
  assign bus.redirect_pending = pend_valid_s;
  assign bus.halted           = halted_r;

endmodule
